button_array: RTL and testbench

Multi-channel debounced push-button front end with short-press, long-press and auto-repeat event detection. It replaces per-button debounce/press logic with one parametrised block that serves a whole button bank. All channels share one tick prescaler. Event outputs are single-clock pulses consumed directly by the clock-setting control logic.

---
 rtl/button_array.sv | 192 +++++++++++++++++++
 tb/tb_button_array.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_array.sv
// button_array: debounced push-button bank with short-press, long-press and
// auto-repeat event pulses. One shared tick prescaler serves every channel.
//
// Event outputs (press, long, repeat_pulse) are registered single-clock
// pulses; a consumer samples them on any rising clock edge. There is no
// backpressure: a pulse is never held waiting for a consumer.
//
// The auto-repeat output is named repeat_pulse because "repeat" is a
// reserved word in SystemVerilog.
module button_array #(
  parameter int CHANNELS       = 4,
  parameter int ACTIVE_LOW     = 1,
  parameter int TICK_DIV       = 14,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int LONG_TICKS     = 64,
  parameter int REPEAT_TICKS   = 16,
  parameter int CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [CHANNELS-1:0]   repeat_en,
  output logic [CHANNELS-1:0]   pressed,
  output logic [CHANNELS-1:0]   press,
  output logic [CHANNELS-1:0]   long,
  output logic [CHANNELS-1:0]   repeat_pulse,
  output logic [2*CHANNELS-1:0] state_dbg
);

  // Raw level of a released button, loaded into the synchronisers on reset.
  localparam logic [CHANNELS-1:0] REST_LEVEL =
    (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] level;
  logic [TICK_DIV-1:0] presc;
  logic                tick;

  logic [CNT_W-1:0] db_cnt [CHANNELS];

  state_t           state_q [CHANNELS];
  state_t           state_d [CHANNELS];
  logic [CNT_W-1:0] hold_q  [CHANNELS];
  logic [CNT_W-1:0] hold_d  [CHANNELS];
  logic [CNT_W-1:0] rcnt_q  [CHANNELS];
  logic [CNT_W-1:0] rcnt_d  [CHANNELS];
  logic [CHANNELS-1:0] press_d;
  logic [CHANNELS-1:0] long_d;
  logic [CHANNELS-1:0] rep_d;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= REST_LEVEL;
      sync2 <= REST_LEVEL;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  // Normalise so that 1 always means "button held down".
  assign level = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Free-running prescaler; tick marks the all-ones count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = &presc;

  // Debounce: a differing level must survive DEBOUNCE_TICKS ticks in a row;
  // any matching sample restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pressed <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (level[i] == pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (tick) begin
          if (db_cnt[i] == DEB_LAST) begin
            pressed[i] <= ~pressed[i];
            db_cnt[i]  <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Event FSM next-state and pulse decode; release always takes priority
  // over a threshold tick in the same cycle.
  always_comb begin
    press_d = '0;
    long_d  = '0;
    rep_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      rcnt_d[i]  = rcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (pressed[i]) begin
            state_d[i] = HELD;
            hold_d[i]  = '0;
          end
        end
        HELD: begin
          if (!pressed[i]) begin
            press_d[i] = 1'b1;
            state_d[i] = IDLE;
          end else if (tick) begin
            if (hold_q[i] == LONG_LAST) begin
              long_d[i]  = 1'b1;
              state_d[i] = LONG;
              rcnt_d[i]  = '0;
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
        end
        LONG: begin
          if (!pressed[i]) begin
            state_d[i] = IDLE;
          end else if (tick) begin
            if (rcnt_q[i] == REP_LAST) begin
              rcnt_d[i] = '0;
              rep_d[i]  = repeat_en[i];
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Event FSM state, counters and registered output pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press        <= '0;
      long         <= '0;
      repeat_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        hold_q[i]  <= '0;
        rcnt_q[i]  <= '0;
      end
    end else begin
      press        <= press_d;
      long         <= long_d;
      repeat_pulse <= rep_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // Flatten per-channel FSM state for observation.
  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_dbg[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: tb/tb_button_array.sv
// Bench for button_array: directed button stimulus, a tick-counting
// behavioural model compared every cycle, plus hand-computed timing checks.
module tb_button_array;
  localparam int CH  = 2;
  localparam int TD  = 2;
  localparam int DEB = 3;
  localparam int LT  = 8;
  localparam int RT  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] in;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] pressed;
  logic [CH-1:0] press;
  logic [CH-1:0] long;
  logic [CH-1:0] repeat_pulse;
  logic [2*CH-1:0] state_dbg;

  button_array #(
    .CHANNELS(CH), .ACTIVE_LOW(1), .TICK_DIV(TD), .DEBOUNCE_TICKS(DEB),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .in(in), .repeat_en(repeat_en),
    .pressed(pressed), .press(press), .long(long),
    .repeat_pulse(repeat_pulse), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: input delay line, run-length debounce, ticks-since-press
  logic [CH-1:0] d1, d2, m_pressed, m_press, m_long, m_rep, m_lvl;
  int phase;
  bit m_tick;
  int m_run [CH];
  bit m_active [CH];
  int m_ticks [CH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      d1 = '1; d2 = '1; phase = 0;
      m_pressed = '0; m_press = '0; m_long = '0; m_rep = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_active[c] = 0; m_ticks[c] = 0;
      end
    end else begin
      m_tick = (phase == (1 << TD) - 1);
      phase  = (phase + 1) % (1 << TD);
      m_lvl  = ~d2;
      m_press = '0; m_long = '0; m_rep = '0;
      for (int c = 0; c < CH; c++) begin
        if (!m_active[c]) begin
          if (m_pressed[c]) begin
            m_active[c] = 1; m_ticks[c] = 0;
          end
        end else if (!m_pressed[c]) begin
          m_press[c]  = (m_ticks[c] < LT);
          m_active[c] = 0;
        end else if (m_tick) begin
          m_ticks[c]++;
          if (m_ticks[c] == LT) m_long[c] = 1'b1;
          else if (m_ticks[c] > LT && ((m_ticks[c] - LT) % RT) == 0) m_rep[c] = repeat_en[c];
        end
        if (m_lvl[c] == m_pressed[c]) m_run[c] = 0;
        else if (m_tick) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_pressed[c] = ~m_pressed[c];
            m_run[c] = 0;
          end
        end
      end
      d2 = d1;
      d1 = in;
    end
  end

  // scoreboard: per-cycle compare plus event bookkeeping
  int n_press [CH];
  int n_long [CH];
  int n_rep [CH];
  int n_long_both = 0;
  int n_rise0 = 0;
  int t_rise0 = 0;
  int t_long0 = 0;
  int t_rep0 = 0;
  bit rep_pend = 0;
  logic prev0 = 1'b0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      n_press[c] = 0; n_long[c] = 0; n_rep[c] = 0;
    end
  end

  always @(negedge clock) begin
    vectors++;
    if ({pressed, press, long, repeat_pulse} !== {m_pressed, m_press, m_long, m_rep}) begin
      miscompares++;
      $display("FAIL cycle_compare cyc=%0d dut pressed=%b press=%b long=%b repeat=%b, model pressed=%b press=%b long=%b repeat=%b",
               cyc, pressed, press, long, repeat_pulse, m_pressed, m_press, m_long, m_rep);
    end
    for (int c = 0; c < CH; c++) begin
      if (press[c] === 1'b1) n_press[c]++;
      if (long[c] === 1'b1) n_long[c]++;
      if (repeat_pulse[c] === 1'b1) n_rep[c]++;
    end
    if (long === 2'b11) n_long_both++;
    if (pressed[0] === 1'b1 && prev0 === 1'b0) begin
      n_rise0++; t_rise0 = cyc;
    end
    prev0 = pressed[0];
    if (long[0] === 1'b1) begin
      t_long0 = cyc; rep_pend = 1;
    end
    if (repeat_pulse[0] === 1'b1 && rep_pend) begin
      t_rep0 = cyc; rep_pend = 0;
    end
  end

  // snapshots taken at the start of each scenario
  int b_press [CH];
  int b_long [CH];
  int b_rep [CH];
  int b_both;
  int b_rise0;

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      b_press[c] = n_press[c]; b_long[c] = n_long[c]; b_rep[c] = n_rep[c];
    end
    b_both  = n_long_both;
    b_rise0 = n_rise0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rise(input int ch, input int budget, input string name);
    int n = 0;
    while (pressed[ch] !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(pressed[ch] === 1'b1), 1);
  endtask

  task automatic wait_long0(input int budget, input string name);
    int n = 0;
    while (long[0] !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(long[0] === 1'b1), 1);
  endtask

  int t0;
  int lat;
  int tr;

  initial begin
    reset = 1'b1; in = 2'b11; repeat_en = 2'b00;
    cycles(3);
    check("reset_outputs", int'({pressed, press, long, repeat_pulse}), 0);
    reset = 1'b0;

    // idle after reset
    snap();
    cycles(100);
    check("idle_pressed", int'(pressed), 0);
    check("idle_events", (n_press[0] - b_press[0]) + (n_press[1] - b_press[1]) +
          (n_long[0] - b_long[0]) + (n_long[1] - b_long[1]) +
          (n_rep[0] - b_rep[0]) + (n_rep[1] - b_rep[1]), 0);

    // bounce rejection: toggle every 3 clocks for 60 clocks
    snap();
    for (int k = 0; k < 20; k++) begin
      in[0] = ~in[0];
      cycles(3);
    end
    in[0] = 1'b1;
    cycles(20);
    check("bounce_no_rise", n_rise0 - b_rise0, 0);
    check("bounce_no_press", n_press[0] - b_press[0], 0);

    // short press: 24 clocks held -> 6 hold ticks, below the long threshold
    snap();
    t0 = cyc;
    in[0] = 1'b0;
    wait_rise(0, 20, "sp_rise_timeout");
    lat = cyc - t0;
    check("sp_rise_latency_le_15", int'(lat <= 15), 1);
    cycles(24 - (cyc - t0));
    in[0] = 1'b1;
    cycles(40);
    check("sp_press_count", n_press[0] - b_press[0], 1);
    check("sp_long_count", n_long[0] - b_long[0], 0);
    check("sp_released", int'(pressed[0]), 0);

    // long press with repeat on channel 0: 120 clocks held -> 30 ticks
    repeat_en = 2'b01;
    snap();
    t0 = cyc;
    in[0] = 1'b0;
    wait_rise(0, 20, "lp_rise_timeout");
    cycles(120 - (cyc - t0));
    in[0] = 1'b1;
    cycles(40);
    check("lp_long_count", n_long[0] - b_long[0], 1);
    check("lp_long_delay", t_long0 - t_rise0, 32);
    check("lp_repeat_count", n_rep[0] - b_rep[0], 5);
    check("lp_first_repeat_gap", t_rep0 - t_long0, 16);
    check("lp_no_press", n_press[0] - b_press[0], 0);

    // both channels, repeat off then enabled on channel 1 late in the hold
    repeat_en = 2'b00;
    snap();
    in = 2'b00;
    cycles(70);
    repeat_en = 2'b10;
    cycles(10);
    in = 2'b11;
    cycles(40);
    repeat_en = 2'b00;
    check("sim_long_both", n_long_both - b_both, 1);
    check("sim_rep_ch0", n_rep[0] - b_rep[0], 0);
    check("sim_rep_ch1", n_rep[1] - b_rep[1], 2);
    check("sim_no_press", (n_press[0] - b_press[0]) + (n_press[1] - b_press[1]), 0);

    // release debounced on the 7th hold tick -> press, no long
    snap();
    in[0] = 1'b0;
    wait_rise(0, 20, "b7_rise_timeout");
    cycles(15);
    in[0] = 1'b1;
    cycles(40);
    check("b7_press", n_press[0] - b_press[0], 1);
    check("b7_no_long", n_long[0] - b_long[0], 0);

    // release debounced on the 8th hold tick -> long, silent release
    snap();
    in[0] = 1'b0;
    wait_rise(0, 20, "b8_rise_timeout");
    cycles(19);
    in[0] = 1'b1;
    cycles(40);
    check("b8_long", n_long[0] - b_long[0], 1);
    check("b8_no_press", n_press[0] - b_press[0], 0);

    // reset while in LONG, button kept held
    snap();
    in[0] = 1'b0;
    wait_rise(0, 20, "rmh_rise1_timeout");
    wait_long0(60, "rmh_long1_timeout");
    cycles(5);
    #2 reset = 1'b1;
    #1;
    check("rmh_outputs_zero", int'({pressed, press, long, repeat_pulse}), 0);
    check("rmh_state_idle", int'(state_dbg), 0);
    cycles(3);
    reset = 1'b0;
    snap();
    wait_rise(0, 30, "rmh_rise2_timeout");
    tr = cyc;
    wait_long0(60, "rmh_long2_timeout");
    check("rmh_long_delay", cyc - tr, 32);
    in[0] = 1'b1;
    cycles(40);
    check("rmh_no_press", n_press[0] - b_press[0], 0);
    check("rmh_long_once", n_long[0] - b_long[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
